// File: rtl/compare_window_tracker_if.sv
// Bundle of the sample stream, window control and result/status signals of
// compare_window_tracker; master drives stimulus, slave is the tracker.
interface compare_window_tracker_if #(
    parameter int BIT  = 4,
    parameter int CNTW = 8
);
    // Handshake: a sample transfers at a rising edge where in_valid && in_ready;
    // in_ready depends only on tracker state, never on in_valid, and res_valid
    // is a one-cycle pulse with no back-pressure.
    logic            start;
    logic [BIT-1:0]  threshold;
    logic [CNTW-1:0] win_len;
    logic            in_valid;
    logic [BIT-1:0]  in_data;
    logic            in_ready;
    logic            res_valid;
    logic            gt;
    logic            eq;
    logic            ls;
    logic [CNTW-1:0] cnt_gt;
    logic [CNTW-1:0] cnt_eq;
    logic [CNTW-1:0] cnt_ls;
    logic [BIT-1:0]  max_val;
    logic [BIT-1:0]  min_val;
    logic            busy;
    logic            done;
    logic [1:0]      dbg_state;

    modport master (
        output start, threshold, win_len, in_valid, in_data,
        input  in_ready, res_valid, gt, eq, ls, cnt_gt, cnt_eq, cnt_ls,
               max_val, min_val, busy, done, dbg_state
    );

    modport slave (
        input  start, threshold, win_len, in_valid, in_data,
        output in_ready, res_valid, gt, eq, ls, cnt_gt, cnt_eq, cnt_ls,
               max_val, min_val, busy, done, dbg_state
    );
endinterface

// File: rtl/compare_window_tracker.sv
// Compares a window of win_len accepted samples against a latched threshold,
// counting gt/eq/ls events and tracking the running max/min of the window.
module compare_window_tracker #(
    parameter int BIT  = 4,
    parameter int CNTW = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    compare_window_tracker_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [BIT-1:0]  threshold_q;
    logic [CNTW-1:0] win_len_q;
    logic [CNTW-1:0] sample_cnt;
    logic            in_ready_r;
    logic            res_valid_r;
    logic            gt_r;
    logic            eq_r;
    logic            ls_r;
    logic [CNTW-1:0] cnt_gt_r;
    logic [CNTW-1:0] cnt_eq_r;
    logic [CNTW-1:0] cnt_ls_r;
    logic [BIT-1:0]  max_r;
    logic [BIT-1:0]  min_r;
    logic            busy_r;
    logic            done_r;
    logic            accept;

    assign accept = bus.in_valid && in_ready_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            threshold_q <= '0;
            win_len_q   <= '0;
            sample_cnt  <= '0;
            in_ready_r  <= 1'b0;
            res_valid_r <= 1'b0;
            gt_r        <= 1'b0;
            eq_r        <= 1'b0;
            ls_r        <= 1'b0;
            cnt_gt_r    <= '0;
            cnt_eq_r    <= '0;
            cnt_ls_r    <= '0;
            max_r       <= '0;
            min_r       <= '1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            // Result flags are pulses: cleared every cycle unless a sample lands.
            res_valid_r <= 1'b0;
            gt_r        <= 1'b0;
            eq_r        <= 1'b0;
            ls_r        <= 1'b0;
            done_r      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        threshold_q <= bus.threshold;
                        win_len_q   <= bus.win_len;
                        sample_cnt  <= '0;
                        cnt_gt_r    <= '0;
                        cnt_eq_r    <= '0;
                        cnt_ls_r    <= '0;
                        max_r       <= '0;
                        min_r       <= '1;
                        busy_r      <= 1'b1;
                        if (bus.win_len == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state      <= RUN;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        res_valid_r <= 1'b1;
                        sample_cnt  <= sample_cnt + CNTW'(1);
                        if (bus.in_data > threshold_q) begin
                            gt_r     <= 1'b1;
                            cnt_gt_r <= cnt_gt_r + CNTW'(1);
                        end else if (bus.in_data == threshold_q) begin
                            eq_r     <= 1'b1;
                            cnt_eq_r <= cnt_eq_r + CNTW'(1);
                        end else begin
                            ls_r     <= 1'b1;
                            cnt_ls_r <= cnt_ls_r + CNTW'(1);
                        end
                        if (bus.in_data > max_r) max_r <= bus.in_data;
                        if (bus.in_data < min_r) min_r <= bus.in_data;
                        // win_len_q is non-zero here, so the subtraction cannot wrap.
                        if (sample_cnt == win_len_q - CNTW'(1)) begin
                            state      <= DONE;
                            done_r     <= 1'b1;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.gt        = gt_r;
    assign bus.eq        = eq_r;
    assign bus.ls        = ls_r;
    assign bus.cnt_gt    = cnt_gt_r;
    assign bus.cnt_eq    = cnt_eq_r;
    assign bus.cnt_ls    = cnt_ls_r;
    assign bus.max_val   = max_r;
    assign bus.min_val   = min_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.dbg_state = state;
endmodule
